// File: rtl/fp_wb_buffer_if.sv
// Result and writeback bundle for fp_wb_buffer.
// slave: the buffer itself. master: the FMA/commit environment that drives it.
interface fp_wb_buffer_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEST_W   = 6,
  parameter int unsigned TICKET_W = 4
);
  logic                issue_i;
  logic                res_valid_i;
  logic [DEST_W-1:0]   res_dest_i;
  logic [TICKET_W-1:0] res_tick_i;
  logic [DATA_W-1:0]   res_data_i;
  logic                busy_fu;
  logic                wb_valid_o;
  logic                wb_ready_i;
  logic [DEST_W-1:0]   wb_dest_o;
  logic [TICKET_W-1:0] wb_tick_o;
  logic [DATA_W-1:0]   wb_data_o;
  logic                overflow_o;

  modport slave (
    input  issue_i, res_valid_i, res_dest_i, res_tick_i, res_data_i, wb_ready_i,
    output busy_fu, wb_valid_o, wb_dest_o, wb_tick_o, wb_data_o, overflow_o
  );

  modport master (
    output issue_i, res_valid_i, res_dest_i, res_tick_i, res_data_i, wb_ready_i,
    input  busy_fu, wb_valid_o, wb_dest_o, wb_tick_o, wb_data_o, overflow_o
  );
endinterface

// File: rtl/fp_wb_buffer.sv
// Writeback buffer behind the fixed-latency FMA pipeline.
// Captures the non-stallable result stream in a small FIFO, drains it over a
// valid/ready writeback port and throttles FMA issue so in-flight results
// always have a slot reserved.
// Optional feature: define FP_WB_BYPASS_EN for a zero-latency path when the
// FIFO is empty and the writeback port is ready.
module fp_wb_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned FU_LAT   = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEST_W   = 6,
  parameter int unsigned TICKET_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_wb_buffer_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if ((DEPTH < FU_LAT + 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_cfg_check
    $error("fp_wb_buffer: DEPTH must be a power of 2 and at least FU_LAT+1");
  end

  typedef struct packed {
    logic [DEST_W-1:0]   dest;
    logic [TICKET_W-1:0] tick;
    logic [DATA_W-1:0]   data;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           res_entry;
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_nxt;
  logic [CNT_W:0]   occupancy;
  logic             overflow;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             pop;
  logic             push;
  logic             drop;

  assign res_entry = '{dest: bus.res_dest_i, tick: bus.res_tick_i, data: bus.res_data_i};
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));

`ifdef FP_WB_BYPASS_EN
  // An empty FIFO with a ready port hands the result straight through and
  // skips the write; if the port is not ready the result is still stored.
  assign bypass         = empty && bus.res_valid_i && bus.wb_ready_i;
  assign bus.wb_valid_o = !empty || bus.res_valid_i;
  assign head           = (empty && bus.res_valid_i) ? res_entry : mem[rd_ptr];
`else
  assign bypass         = 1'b0;
  assign bus.wb_valid_o = !empty;
  assign head           = mem[rd_ptr];
`endif

  assign pop  = !empty && bus.wb_ready_i;
  assign drop = bus.res_valid_i && full && !pop;
  assign push = bus.res_valid_i && !bypass && !drop;

  assign bus.wb_dest_o  = head.dest;
  assign bus.wb_tick_o  = head.tick;
  assign bus.wb_data_o  = head.data;
  assign bus.overflow_o = overflow;

  // Reservation check uses registered state only, so issue_i never loops back.
  assign occupancy   = {1'b0, count} + {1'b0, inflight};
  assign bus.busy_fu = (occupancy >= (CNT_W + 1)'(DEPTH));

  // Next occupancy and in-flight count; results with nothing in flight do not underflow.
  always_comb begin
    count_nxt    = count;
    inflight_nxt = inflight;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
    if (bus.issue_i && !bus.res_valid_i) begin
      inflight_nxt = inflight + 1'b1;
    end else if (!bus.issue_i && bus.res_valid_i && (inflight != '0)) begin
      inflight_nxt = inflight - 1'b1;
    end
  end

  // Pointers, counters and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      inflight <= inflight_nxt;
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage; cleared on reset so the idle payload reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= res_entry;
    end
  end

endmodule
